// File: rtl/clk_freq_meter.sv
// Counts rising edges (and, with CLK_FREQ_METER_DUTY_EN, high time) of meas_clk_i over a window of clk_i cycles.
// Latency: win_q cycles after the aligning edge. Results are held in DONE until res_ready_i; no new start is accepted meanwhile.
module clk_freq_meter #(
  parameter int WIN_WIDTH   = 16,
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 meas_clk_i,
  input  logic [WIN_WIDTH-1:0] win_i,
  input  logic                 start_valid_i,
  output logic                 start_ready_o,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [CNT_WIDTH-1:0] res_edge_o,
  output logic [WIN_WIDTH-1:0] res_high_o,
  output logic                 res_ovf_o,
  output logic                 res_tmo_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   meas_lvl, rise;
  logic [WIN_WIDTH-1:0]   win_q, cnt_q;
  logic [CNT_WIDTH-1:0]   edge_q, edge_nxt, res_edge_q;
  logic                   ovf_q, ovf_nxt, res_ovf_q, res_tmo_q;
  logic                   start_hs, last_win, edge_inc, edge_sat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], meas_clk_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign meas_lvl = sync_q[SYNC_STAGES-1];
  assign rise     = meas_lvl & ~prev_q;

  assign start_hs = start_valid_i && (state_q == IDLE);
  assign last_win = (state_q == MEAS) && (cnt_q == win_q - 1'b1);
  assign edge_inc = (state_q == MEAS) && rise;
  assign edge_sat = &edge_q;
  assign edge_nxt = (edge_inc && !edge_sat) ? edge_q + 1'b1 : edge_q;
  assign ovf_nxt  = ovf_q | (edge_inc & edge_sat);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_valid_i) state_d = (win_i == '0) ? DONE : ARM;
      ARM: begin
        // The aligning edge wins over a timeout landing in the same cycle.
        if (rise)                state_d = MEAS;
        else if (cnt_q == win_q) state_d = DONE;
      end
      MEAS: if (last_win) state_d = DONE;
      DONE: if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      win_q      <= '0;
      cnt_q      <= '0;
      edge_q     <= '0;
      ovf_q      <= 1'b0;
      res_edge_q <= '0;
      res_ovf_q  <= 1'b0;
      res_tmo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start_hs) begin
          win_q      <= win_i;
          cnt_q      <= '0;
          edge_q     <= '0;
          ovf_q      <= 1'b0;
          res_edge_q <= '0;
          res_ovf_q  <= 1'b0;
          res_tmo_q  <= 1'b0;
        end
        ARM: begin
          if (rise)                cnt_q     <= '0;
          else if (cnt_q == win_q) res_tmo_q <= 1'b1;
          else                     cnt_q     <= cnt_q + 1'b1;
        end
        MEAS: begin
          cnt_q  <= cnt_q + 1'b1;
          edge_q <= edge_nxt;
          ovf_q  <= ovf_nxt;
          if (last_win) begin
            res_edge_q <= edge_nxt;
            res_ovf_q  <= ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CLK_FREQ_METER_DUTY_EN
  logic [WIN_WIDTH-1:0] high_q, high_nxt, res_high_q;

  assign high_nxt = high_q + WIN_WIDTH'(meas_lvl);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      high_q     <= '0;
      res_high_q <= '0;
    end else if (start_hs) begin
      high_q     <= '0;
      res_high_q <= '0;
    end else if (state_q == MEAS) begin
      high_q <= high_nxt;
      if (last_win) res_high_q <= high_nxt;
    end
  end

  assign res_high_o = res_high_q;
`else
  assign res_high_o = '0;
`endif

  assign start_ready_o = (state_q == IDLE);
  assign res_valid_o   = (state_q == DONE);
  assign busy_o        = (state_q != IDLE);
  assign res_edge_o    = res_edge_q;
  assign res_ovf_o     = res_ovf_q;
  assign res_tmo_o     = res_tmo_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Scoreboard bench for clk_freq_meter: a default-width instance plus a CNT_WIDTH=2 instance for saturation.
module tb_clk_freq_meter;

`ifdef CLK_FREQ_METER_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  typedef struct {
    int edges;
    int high;
    int ovf;
    int tmo;
    int lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        meas_clk = 1'b0;
  logic [15:0] win = '0;
  logic        start_valid = 1'b0, start_ready, res_valid, res_ready = 1'b0;
  logic [15:0] res_edge, res_high;
  logic        res_ovf, res_tmo, busy;

  logic [15:0] win2 = '0;
  logic        start2_valid = 1'b0, start2_ready, res2_valid, res2_ready = 1'b0;
  logic [1:0]  res2_edge;
  logic [15:0] res2_high;
  logic        res2_ovf, res2_tmo, busy2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int div = 0;
  exp_t q1[$];
  exp_t q2[$];

  clk_freq_meter u_dut (
    .clk_i(clk), .rst_i(rst_i), .meas_clk_i(meas_clk), .win_i(win),
    .start_valid_i(start_valid), .start_ready_o(start_ready),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_edge_o(res_edge), .res_high_o(res_high),
    .res_ovf_o(res_ovf), .res_tmo_o(res_tmo), .busy_o(busy)
  );

  clk_freq_meter #(.WIN_WIDTH(16), .CNT_WIDTH(2), .SYNC_STAGES(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst_i), .meas_clk_i(meas_clk), .win_i(win2),
    .start_valid_i(start2_valid), .start_ready_o(start2_ready),
    .res_valid_o(res2_valid), .res_ready_i(res2_ready),
    .res_edge_o(res2_edge), .res_high_o(res2_high),
    .res_ovf_o(res2_ovf), .res_tmo_o(res2_tmo), .busy_o(busy2)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Measured clock derived from clk, toggling on the falling edge; div==0 holds it low.
  initial begin
    int ph = 0;
    forever begin
      @(negedge clk);
      if (div == 0) begin
        meas_clk = 1'b0;
        ph = 0;
      end else begin
        ph++;
        if (ph >= div / 2) begin
          meas_clk = ~meas_clk;
          ph = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor for the main instance.
  initial begin
    bit   in_res = 1'b0, prev_hs = 1'b0;
    exp_t e;
    int   s_edge = 0, s_high = 0, s_ovf = 0, s_tmo = 0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        in_res = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (prev_hs) chk("start_ready_after_res_hs", int'(start_ready), 1);
        prev_hs = 1'b0;
        if (start_valid && start_ready) hs_cyc = cyc;
        if (res_valid) begin
          chk("start_blocked_in_done", int'(start_ready), 0);
          if (!in_res) begin
            if (q1.size() == 0) begin
              chk("unexpected_result", 1, 0);
            end else begin
              e = q1.pop_front();
              chk("res_edge", int'(res_edge), e.edges);
              chk("res_high", int'(res_high), e.high);
              chk("res_ovf", int'(res_ovf), e.ovf);
              chk("res_tmo", int'(res_tmo), e.tmo);
              if (e.lat >= 0) chk("res_valid_latency", cyc - hs_cyc, e.lat);
            end
            s_edge = int'(res_edge); s_high = int'(res_high);
            s_ovf = int'(res_ovf);   s_tmo = int'(res_tmo);
            in_res = 1'b1;
          end else begin
            chk("hold_edge", int'(res_edge), s_edge);
            chk("hold_high", int'(res_high), s_high);
            chk("hold_flags", int'({res_ovf, res_tmo}), int'({s_ovf[0], s_tmo[0]}));
          end
          if (res_ready) begin
            in_res = 1'b0;
            prev_hs = 1'b1;
          end
        end
      end
    end
  end

  // Monitor for the narrow-count instance.
  initial begin
    bit   in_res = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        in_res = 1'b0;
      end else if (res2_valid) begin
        if (!in_res) begin
          if (q2.size() == 0) begin
            chk("unexpected_result2", 1, 0);
          end else begin
            e = q2.pop_front();
            chk("res2_edge", int'(res2_edge), e.edges);
            chk("res2_high", int'(res2_high), e.high);
            chk("res2_ovf", int'(res2_ovf), e.ovf);
            chk("res2_tmo", int'(res2_tmo), e.tmo);
          end
          in_res = 1'b1;
        end
        if (res2_ready) in_res = 1'b0;
      end
    end
  end

  task automatic set_div(input int d);
    div = d;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic start1(input logic [15:0] w);
    @(posedge clk); #1;
    win = w;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  // Waits for the result, stalls for 'hold' cycles (optionally requesting a new start meanwhile), then consumes it.
  task automatic finish1(input int hold, input bit poke);
    int n = 0;
    while (!res_valid && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!res_valid) begin
      chk("res_valid_timeout", 0, 1);
    end else begin
      repeat (hold) begin
        start_valid = poke;
        @(posedge clk); #1;
      end
      start_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic push1(input int e, input int h, input int o, input int t, input int l);
    exp_t x;
    x.edges = e; x.high = DUTY ? h : 0; x.ovf = o; x.tmo = t; x.lat = l;
    q1.push_back(x);
  endtask

  initial begin
    exp_t x;
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("reset_start_ready", int'(start_ready), 1);
    chk("reset_res_valid", int'(res_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_results", int'({res_edge, res_high, res_ovf, res_tmo}), 0);

    // clk/4, window 16
    set_div(4);
    push1(4, 8, 0, 0, -1);
    start1(16);
    finish1(0, 1'b0);

    // stopped clock: timeout
    set_div(0);
    push1(0, 0, 0, 1, 12);
    start1(10);
    finish1(0, 1'b0);

    // zero window
    set_div(4);
    push1(0, 0, 0, 0, 1);
    start1(0);
    finish1(0, 1'b0);

    // backpressure with start requests held during DONE
    set_div(6);
    push1(4, 12, 0, 0, -1);
    start1(24);
    finish1(5, 1'b1);

    // reset in the middle of a measurement
    start1(24);
    repeat (15) @(posedge clk);
    #1;
    chk("busy_mid_meas", int'(busy), 1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_start_ready", int'(start_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_results", int'({res_edge, res_high, res_ovf, res_tmo}), 0);
    set_div(6);
    push1(4, 12, 0, 0, -1);
    start1(24);
    finish1(0, 1'b0);

    // saturation on the 2-bit counter, clk/2, window 20
    set_div(2);
    x.edges = 3; x.high = DUTY ? 10 : 0; x.ovf = 1; x.tmo = 0; x.lat = -1;
    q2.push_back(x);
    @(posedge clk); #1;
    win2 = 16'd20;
    start2_valid = 1'b1;
    @(posedge clk); #1;
    start2_valid = 1'b0;
    n = 0;
    while (!res2_valid && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!res2_valid) chk("res2_valid_timeout", 0, 1);
    res2_ready = 1'b1;
    @(posedge clk); #1;
    res2_ready = 1'b0;
    @(posedge clk); #1;

    chk("scoreboard1_drained", q1.size(), 0);
    chk("scoreboard2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
